agc_amplitude_meter: RTL

Downstream consumer of the auto-gain controller. Measures the peak-to-peak amplitude of adc_data over a fixed window, but only while the AGC reports stable. It removes the selected analog gain (3, 6.5, 13.5 or 29.25x) and reports the input-referred Vpp in 0.1 mV units. The result goes to the display/measurement logic with a one-cycle valid pulse.

---
 rtl/agc_pkg.sv | 35 +++
 rtl/agc_scale_mult.sv | 52 +++++
 rtl/agc_amplitude_meter.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/agc_pkg.sv
// agc_pkg: types and constants shared by the AGC controller and the
// amplitude meter (state encoding, gain codes, Q16 de-gain coefficients).
package agc_pkg;

    typedef logic [1:0] gain_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_ACQUIRE,
        S_MULT,
        S_SCALE
    } meter_state_t;

    localparam logic [11:0] ADC_MAX = 12'd4095;
    localparam int          Q_SHIFT = 16;
    localparam logic [28:0] Q_HALF  = 29'(1 << (Q_SHIFT - 1));

    // Q16 of (2000/4096 * 10 / gain) for gains 3, 6.5, 13.5, 29.25
    localparam logic [16:0] K_COEF [4] = '{
        17'd106667,
        17'd49231,
        17'd23704,
        17'd10940
    };

    // Upstream AGC level thresholds (ADC codes)
    localparam logic [11:0] AGC_THR_HI = 12'd3686;
    localparam logic [11:0] AGC_THR_LO = 12'd1024;

    function automatic logic [16:0] k_of(input gain_t g);
        return K_COEF[g];
    endfunction

endpackage

// File: rtl/agc_scale_mult.sv
// agc_scale_mult: two-stage pp * K[gain] followed by round-half-up >> 16.
// res holds its value until the next valid result.
module agc_scale_mult
    import agc_pkg::*;
(
    input  logic        adc_clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [11:0] pp,
    input  logic [1:0]  gain,
    output logic        out_valid,
    output logic [15:0] res
);

    logic [28:0] prod_q, prod_d;
    logic        v1_q, v1_d;
    logic [15:0] res_q, res_d;
    logic        v2_q, v2_d;

    // Stage 1 product, stage 2 rounding and Q16 removal
    always_comb begin
        prod_d = prod_q;
        res_d  = res_q;
        v1_d   = in_valid;
        v2_d   = v1_q;
        if (in_valid) begin
            prod_d = 29'(pp) * 29'(k_of(gain));
        end
        if (v1_q) begin
            res_d = 16'((prod_q + Q_HALF) >> Q_SHIFT);
        end
    end

    // Pipeline registers
    always_ff @(posedge adc_clk or negedge rst_n) begin
        if (!rst_n) begin
            prod_q <= '0;
            v1_q   <= 1'b0;
            res_q  <= '0;
            v2_q   <= 1'b0;
        end else begin
            prod_q <= prod_d;
            v1_q   <= v1_d;
            res_q  <= res_d;
            v2_q   <= v2_d;
        end
    end

    assign out_valid = v2_q;
    assign res       = res_q;

endmodule

// File: rtl/agc_amplitude_meter.sv
// agc_amplitude_meter: windowed peak-to-peak meter, input-referred in 0.1 mV.
// Define AGC_AMP_AVG_EN to average the last 4 window results.
module agc_amplitude_meter
    import agc_pkg::*;
#(
    parameter int WINDOW = 1024,
    parameter int SETTLE = 16
) (
    input  logic        adc_clk,
    input  logic        rst_n,
    input  logic [11:0] adc_data,
    input  logic [1:0]  gain_ctrl,
    input  logic        stable,
    output logic [15:0] amp_vpp,
    output logic [1:0]  amp_gain,
    output logic        amp_clip,
    output logic        amp_valid,
    output logic        busy
);

    localparam int CW = $clog2(WINDOW);

    meter_state_t  state_q, state_d;
    logic [7:0]    set_cnt_q, set_cnt_d;
    logic [CW-1:0] smp_cnt_q, smp_cnt_d;
    logic [11:0]   max_q, max_d;
    logic [11:0]   min_q, min_d;
    logic          clip_q, clip_d;
    gain_t         gain_lat_q, gain_lat_d;
    gain_t         gain_o_q, gain_o_d;
    logic          clip_o_q, clip_o_d;

    logic          samp_clip;
    logic          abort;
    logic          set_done;
    logic          win_done;
    logic          mult_en;
    logic          m_valid;
    logic [15:0]   m_res;

    assign samp_clip = (adc_data == 12'd0) || (adc_data == ADC_MAX);
    assign abort     = ((state_q == S_SETTLE) || (state_q == S_ACQUIRE)) &&
                       (!stable || (gain_ctrl != gain_lat_q));
    assign set_done  = (set_cnt_q == 8'(SETTLE - 1));
    assign win_done  = (smp_cnt_q == CW'(WINDOW - 1));

    // State register
    always_ff @(posedge adc_clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next state; abort wins over window completion
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:    if (stable) state_d = S_SETTLE;
            S_SETTLE:  if (abort) state_d = S_IDLE;
                       else if (set_done) state_d = S_ACQUIRE;
            S_ACQUIRE: if (abort) state_d = S_IDLE;
                       else if (win_done) state_d = S_MULT;
            S_MULT:    state_d = S_SCALE;
            S_SCALE:   state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        mult_en = (state_q == S_MULT);
        busy    = (state_q != S_IDLE);
    end

    // Window datapath: counters, running max/min/clip, result tags
    always_comb begin
        set_cnt_d  = set_cnt_q;
        smp_cnt_d  = smp_cnt_q;
        max_d      = max_q;
        min_d      = min_q;
        clip_d     = clip_q;
        gain_lat_d = gain_lat_q;
        gain_o_d   = gain_o_q;
        clip_o_d   = clip_o_q;
        unique case (state_q)
            S_IDLE: begin
                smp_cnt_d = '0;
                if (stable) begin
                    gain_lat_d = gain_ctrl;
                    set_cnt_d  = '0;
                end
            end
            S_SETTLE: begin
                set_cnt_d = set_cnt_q + 8'd1;
                smp_cnt_d = '0;
            end
            S_ACQUIRE: begin
                smp_cnt_d = smp_cnt_q + 1'b1;
                if (smp_cnt_q == '0) begin
                    max_d  = adc_data;
                    min_d  = adc_data;
                    clip_d = samp_clip;
                end else begin
                    if (adc_data > max_q) max_d = adc_data;
                    if (adc_data < min_q) min_d = adc_data;
                    clip_d = clip_q | samp_clip;
                end
            end
            S_SCALE: begin
                gain_o_d = gain_lat_q;
                clip_o_d = clip_q;
            end
            default: ;
        endcase
    end

    // Window datapath registers
    always_ff @(posedge adc_clk or negedge rst_n) begin
        if (!rst_n) begin
            set_cnt_q  <= '0;
            smp_cnt_q  <= '0;
            max_q      <= '0;
            min_q      <= '0;
            clip_q     <= 1'b0;
            gain_lat_q <= '0;
            gain_o_q   <= '0;
            clip_o_q   <= 1'b0;
        end else begin
            set_cnt_q  <= set_cnt_d;
            smp_cnt_q  <= smp_cnt_d;
            max_q      <= max_d;
            min_q      <= min_d;
            clip_q     <= clip_d;
            gain_lat_q <= gain_lat_d;
            gain_o_q   <= gain_o_d;
            clip_o_q   <= clip_o_d;
        end
    end

    agc_scale_mult u_mult (
        .adc_clk   (adc_clk),
        .rst_n     (rst_n),
        .in_valid  (mult_en),
        .pp        (max_q - min_q),
        .gain      (gain_lat_q),
        .out_valid (m_valid),
        .res       (m_res)
    );

`ifdef AGC_AMP_AVG_EN
    logic [3:0][15:0] hist_q, hist_d;
    logic [3:0]       hclip_q, hclip_d;
    logic [17:0]      sum_q, sum_d;
    logic [2:0]       cnt_q, cnt_d;
    logic [15:0]      avg_vpp_q, avg_vpp_d;
    gain_t            avg_gain_q, avg_gain_d;
    logic             avg_clip_q, avg_clip_d;
    logic             avg_vld_q, avg_vld_d;

    // 4-deep history with running sum; aborts empty it
    always_comb begin
        hist_d     = hist_q;
        hclip_d    = hclip_q;
        sum_d      = sum_q;
        cnt_d      = cnt_q;
        avg_vpp_d  = avg_vpp_q;
        avg_gain_d = avg_gain_q;
        avg_clip_d = avg_clip_q;
        avg_vld_d  = 1'b0;
        if (abort) begin
            hist_d  = '0;
            hclip_d = '0;
            sum_d   = '0;
            cnt_d   = '0;
        end else if (m_valid) begin
            hist_d  = {hist_q[2:0], m_res};
            hclip_d = {hclip_q[2:0], clip_o_q};
            sum_d   = sum_q - 18'(hist_q[3]) + 18'(m_res);
            if (cnt_q != 3'd4) cnt_d = cnt_q + 3'd1;
            if (cnt_q >= 3'd3) begin
                avg_vld_d  = 1'b1;
                avg_vpp_d  = 16'((sum_d + 18'd2) >> 2);
                avg_gain_d = gain_o_q;
                avg_clip_d = |hclip_d;
            end
        end
    end

    // Averager registers
    always_ff @(posedge adc_clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_q     <= '0;
            hclip_q    <= '0;
            sum_q      <= '0;
            cnt_q      <= '0;
            avg_vpp_q  <= '0;
            avg_gain_q <= '0;
            avg_clip_q <= 1'b0;
            avg_vld_q  <= 1'b0;
        end else begin
            hist_q     <= hist_d;
            hclip_q    <= hclip_d;
            sum_q      <= sum_d;
            cnt_q      <= cnt_d;
            avg_vpp_q  <= avg_vpp_d;
            avg_gain_q <= avg_gain_d;
            avg_clip_q <= avg_clip_d;
            avg_vld_q  <= avg_vld_d;
        end
    end

    assign amp_vpp   = avg_vpp_q;
    assign amp_gain  = avg_gain_q;
    assign amp_clip  = avg_clip_q;
    assign amp_valid = avg_vld_q;
`else
    assign amp_vpp   = m_res;
    assign amp_gain  = gain_o_q;
    assign amp_clip  = clip_o_q;
    assign amp_valid = m_valid;
`endif

endmodule
